// File: rtl/apple_gen_inside_body_pkg.sv
// Shared widths, limits and FSM state encoding for the apple collision checker.
// Imported by the interface, the overlap compare and the top.
package apple_gen_inside_body_pkg;
    localparam int X_W      = 8;
    localparam int Y_W      = 9;
    localparam int MAX_SEGS = 128;
    localparam int CMP_W    = 10;
    localparam int IDX_W    = $clog2(MAX_SEGS);
    localparam int SNX_W    = MAX_SEGS * X_W;
    localparam int SNY_W    = MAX_SEGS * Y_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;
endpackage

// File: rtl/apple_gen_inside_body_if.sv
// Bus between the apple generator / game state and the collision checker.
// master: drives snake body, size, apple position and frame tick; reads result.
// slave : the checker.
interface apple_gen_inside_body_if;
    import apple_gen_inside_body_pkg::*;

    logic [SNX_W-1:0] snakeLocX;
    logic [SNY_W-1:0] snakeLocY;
    logic [7:0]       size;
    logic             screenClock;
    logic [X_W-1:0]   appleLocX;
    logic [Y_W-1:0]   appleLocY;
    logic             appleFoundInsideBody;

    modport master (
        output snakeLocX, snakeLocY, size, screenClock,
        output appleLocX, appleLocY,
        input  appleFoundInsideBody
    );

    modport slave (
        input  snakeLocX, snakeLocY, size, screenClock,
        input  appleLocX, appleLocY,
        output appleFoundInsideBody
    );
endinterface

// File: rtl/apple_gen_inside_body_overlap.sv
// Combinational rectangle intersection of one snake segment against the apple.
// Ports: ax_i/ay_i apple top-left, sx_i/sy_i segment top-left, hit_o overlap.
module apple_seg_overlap
    import apple_gen_inside_body_pkg::*;
#(
    parameter int SegWidth    = 10,
    parameter int SegHeight   = 10,
    parameter int AppleWidth  = 10,
    parameter int AppleHeight = 10
) (
    input  logic [X_W-1:0] ax_i,
    input  logic [Y_W-1:0] ay_i,
    input  logic [X_W-1:0] sx_i,
    input  logic [Y_W-1:0] sy_i,
    output logic           hit_o
);
    logic [CMP_W-1:0] ax, ay, sx, sy;
    logic             x_ov, y_ov;

    assign ax = CMP_W'(ax_i);
    assign ay = CMP_W'(ay_i);
    assign sx = CMP_W'(sx_i);
    assign sy = CMP_W'(sy_i);

    // Strict compares: rectangles that only share an edge do not overlap.
    assign x_ov = (ax < sx + CMP_W'(SegWidth)) &&
                  (sx < ax + CMP_W'(AppleWidth));
    assign y_ov = (ay < sy + CMP_W'(SegHeight)) &&
                  (sy < ay + CMP_W'(AppleHeight));

    assign hit_o = x_ov && y_ov;
endmodule

// File: rtl/apple_gen_inside_body.sv
// Checks whether a candidate apple overlaps any active snake segment, one
// segment per clock, once per screenClock rise. Ports: clock, reset (sync,
// active-high), bus (slave modport). Optional APPLE_GEN_BORDER_CHECK_EN also
// flags apples outside the playable area.
module apple_gen_inside_body
    import apple_gen_inside_body_pkg::*;
#(
    parameter int SegWidth        = 10,
    parameter int SegHeight       = 10,
    parameter int BorderThickness = 10,
    parameter int AppleWidth      = 10,
    parameter int AppleHeight     = 10,
    parameter int DisplayWidth    = 240,
    parameter int DisplayHeight   = 320
) (
    input  logic                    clock,
    input  logic                    reset,
    apple_gen_inside_body_if.slave  bus
);
    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_SCAN = SCAN;
    localparam logic [1:0] S_DONE = DONE;

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       size_q, size_d;
    logic [X_W-1:0]   ax_q, ax_d;
    logic [Y_W-1:0]   ay_q, ay_d;
    logic             hit_q, hit_d;
    logic             found_q, found_d;
    logic             sc_q, prev_q;

    logic             rise;
    logic [7:0]       size_clamped;
    logic [9:0]       xbase;
    logic [10:0]      ybase;
    logic [X_W-1:0]   seg_x;
    logic [Y_W-1:0]   seg_y;
    logic             seg_hit;
    logic             last;
    logic             oob;
    logic             start_hit;
    logic [CMP_W-1:0] lax, lay;

    // Tick is registered, then compared against its own history.
    assign rise = sc_q & ~prev_q;

    assign size_clamped = (bus.size > 8'(MAX_SEGS)) ? 8'(MAX_SEGS)
                                                    : bus.size;

    assign xbase = {idx_q, 3'b000};
    assign ybase = 11'(idx_q) * 11'd9;
    assign seg_x = bus.snakeLocX[xbase +: X_W];
    assign seg_y = bus.snakeLocY[ybase +: Y_W];

    assign last = ({1'b0, idx_q} == size_q - 8'd1);

    apple_seg_overlap #(
        .SegWidth   (SegWidth),
        .SegHeight  (SegHeight),
        .AppleWidth (AppleWidth),
        .AppleHeight(AppleHeight)
    ) u_overlap (
        .ax_i (ax_q),
        .ay_i (ay_q),
        .sx_i (seg_x),
        .sy_i (seg_y),
        .hit_o(seg_hit)
    );

    assign lax = CMP_W'(bus.appleLocX);
    assign lay = CMP_W'(bus.appleLocY);
    assign oob =
        (lax < CMP_W'(BorderThickness)) ||
        (lax + CMP_W'(AppleWidth) >
         CMP_W'(DisplayWidth - BorderThickness)) ||
        (lay < CMP_W'(BorderThickness)) ||
        (lay + CMP_W'(AppleHeight) >
         CMP_W'(DisplayHeight - BorderThickness));

`ifdef APPLE_GEN_BORDER_CHECK_EN
    assign start_hit = oob;
`else
    logic unused_oob;
    assign unused_oob = oob;
    assign start_hit  = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        size_d  = size_q;
        ax_d    = ax_q;
        ay_d    = ay_q;
        hit_d   = hit_q;
        found_d = found_q;
        unique case (state_q)
            S_IDLE: begin
                if (rise) begin
                    ax_d    = bus.appleLocX;
                    ay_d    = bus.appleLocY;
                    size_d  = size_clamped;
                    idx_d   = '0;
                    hit_d   = start_hit;
                    state_d = (size_clamped == 8'd0) ? S_DONE : S_SCAN;
                end
            end
            S_SCAN: begin
                hit_d = hit_q | seg_hit;
                idx_d = idx_q + 1'b1;
                if (last) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                found_d = hit_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            size_q  <= '0;
            ax_q    <= '0;
            ay_q    <= '0;
            hit_q   <= 1'b0;
            found_q <= 1'b0;
            sc_q    <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            size_q  <= size_d;
            ax_q    <= ax_d;
            ay_q    <= ay_d;
            hit_q   <= hit_d;
            found_q <= found_d;
            sc_q    <= bus.screenClock;
            prev_q  <= sc_q;
        end
    end

    assign bus.appleFoundInsideBody = found_q;
endmodule

// File: tb/tb_apple_gen_inside_body.sv
// Scoreboard bench for apple_gen_inside_body: directed checks queue expected
// (cycle, value) pairs; a negedge monitor pops and compares them.
module tb_apple_gen_inside_body;
    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   failures;
    logic model_out;

    typedef struct {
        int    at;
        int    val;
        string nm;
    } exp_t;

    exp_t sb[$];
    exp_t ex;

    apple_gen_inside_body_if bus();

    apple_gen_inside_body dut (
        .clock(clk),
        .reset(rst),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

`ifdef APPLE_GEN_BORDER_CHECK_EN
    localparam logic BORDER = 1'b1;
`else
    localparam logic BORDER = 1'b0;
`endif

    task automatic check(input string nm, input int act, input int expv);
        checks = checks + 1;
        if (act !== expv) begin
            failures = failures + 1;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    task automatic push(input int at, input int val, input string nm);
        exp_t e;
        e.at  = at;
        e.val = val;
        e.nm  = nm;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0 && cyc >= sb[0].at) begin
            ex = sb.pop_front();
            if (cyc == ex.at)
                check(ex.nm, int'(bus.appleFoundInsideBody), ex.val);
            else
                check({ex.nm, "_missed"}, cyc, ex.at);
        end
    end

    task automatic set_seg(input int i, input int x, input int y);
        bus.snakeLocX[i*8 +: 8] = 8'(x);
        bus.snakeLocY[i*9 +: 9] = 9'(y);
    endtask

    // One full check: result expected 3+size edges after the tick is
    // driven; the old value must still be there one edge earlier.
    task automatic run_check(input string nm, input int sz, input int ax,
                             input int ay, input logic expv);
        int e0;
        int se;
        se = (sz > 128) ? 128 : sz;
        @(negedge clk);
        bus.appleLocX = 8'(ax);
        bus.appleLocY = 9'(ay);
        bus.size      = 8'(sz);
        e0 = cyc;
        bus.screenClock = 1'b1;
        push(e0 + 2 + se, int'(model_out), {nm, "_hold"});
        push(e0 + 3 + se, int'(expv), nm);
        model_out = expv;
        @(negedge clk);
        bus.screenClock = 1'b0;
        repeat (se + 4) @(negedge clk);
    endtask

    initial begin
        int e0;
        checks = 0;
        failures = 0;
        model_out = 1'b0;
        rst = 1'b1;
        bus.snakeLocX = '0;
        bus.snakeLocY = '0;
        bus.size = 8'd0;
        bus.screenClock = 1'b0;
        bus.appleLocX = 8'd0;
        bus.appleLocY = 9'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_out", int'(bus.appleFoundInsideBody), 0);
        check("reset_state", int'(dut.state_q), 0);

        set_seg(0, 100, 150);
        run_check("hit_head", 1, 100, 150, 1'b1);

        for (int i = 0; i < 5; i++) set_seg(i, 20 * i, 20 * i);
        run_check("miss_diag", 5, 100, 150, 1'b0);

        set_seg(0, 100, 150);
        run_check("corner_in", 1, 109, 159, 1'b1);
        run_check("touch_x", 1, 110, 150, 1'b0);
        run_check("corner_in2", 1, 109, 159, 1'b1);
        run_check("touch_y", 1, 100, 160, 1'b0);
        run_check("corner_in3", 1, 109, 159, 1'b1);
        run_check("size0", 0, 100, 150, 1'b0);

        set_seg(0, 0, 0);
        set_seg(127, 100, 150);
        run_check("seg127", 128, 100, 150, 1'b1);
        run_check("size127", 127, 100, 150, 1'b0);
        run_check("size200", 200, 100, 150, 1'b1);

        // Reset in the middle of a long scan.
        @(negedge clk);
        bus.size = 8'd128;
        bus.screenClock = 1'b1;
        @(negedge clk);
        bus.screenClock = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midreset_out", int'(bus.appleFoundInsideBody), 0);
        check("midreset_state", int'(dut.state_q), 0);
        rst = 1'b0;
        model_out = 1'b0;
        push(cyc + 140, 0, "post_reset");
        repeat (145) @(negedge clk);

        // A second tick during SCAN must not queue another check.
        set_seg(127, 0, 0);
        for (int i = 0; i < 5; i++) set_seg(i, 20 * i, 20 * i);
        @(negedge clk);
        bus.appleLocX = 8'd100;
        bus.appleLocY = 9'd150;
        bus.size = 8'd5;
        e0 = cyc;
        bus.screenClock = 1'b1;
        push(e0 + 8, 0, "dbl_first");
        @(negedge clk);
        bus.screenClock = 1'b0;
        repeat (3) @(negedge clk);
        bus.screenClock = 1'b1;
        repeat (6) @(negedge clk);
        set_seg(0, 100, 150);
        push(e0 + 30, 0, "dbl_ignored");
        repeat (24) @(negedge clk);
        bus.screenClock = 1'b0;
        repeat (4) @(negedge clk);

        set_seg(0, 0, 0);
        run_check("border_left", 1, 5, 150, BORDER);
        run_check("inside_clear", 1, 100, 150, 1'b0);
        run_check("border_right", 1, 225, 150, BORDER);

        for (int i = 0; i < 500 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) check("sb_drain", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
